// File: rtl/tile_renderer.sv
// Tile playfield renderer: 640x480 VGA timing over a background ROM, with a
// palette-coloured cell grid, a next-piece preview and a game-over blink.
module tile_renderer #(
  parameter int unsigned GRID_COLS  = 10,
  parameter int unsigned GRID_ROWS  = 20,
  parameter int unsigned CELL_W     = 3,
  parameter int unsigned TILE_PX    = 14,
  parameter int unsigned ORG_X      = 208,
  parameter int unsigned ORG_Y      = 105,
  parameter int unsigned PREV_X     = 368,
  parameter int unsigned PREV_Y     = 279,
  parameter logic [12*(2**CELL_W)-1:0] PALETTE = {12'hFFF, 12'hA0F, 12'h0F0, 12'hFF0,
                                                  12'hF80, 12'h00F, 12'h0FF, 12'h000},
  parameter logic [11:0] BORDER_COLOR = 12'h000,
  parameter logic [11:0] FAIL_COLOR   = 12'hF00,
  parameter int unsigned BLINK_LOG2   = 4
) (
  input  logic                                 clk,
  input  logic                                 clr,
  input  logic [GRID_COLS*GRID_ROWS*CELL_W-1:0] cell_data,
  input  logic [2:0]                           next_type,
  input  logic                                 fail,
  output logic [18:0]                          bg_addr,
  input  logic [11:0]                          bg_data,
  output logic                                 hs,
  output logic                                 vs,
  output logic [3:0]                           r,
  output logic [3:0]                           g,
  output logic [3:0]                           b,
  output logic                                 frame_start
);

  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_TOTAL = 525;
  localparam int unsigned H_VIS   = 640;
  localparam int unsigned V_VIS   = 480;
  localparam int unsigned NCELLS  = GRID_COLS * GRID_ROWS;
  localparam int unsigned CIDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int unsigned TX_W    = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int unsigned TY_W    = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int unsigned OFF_W   = $clog2(TILE_PX);
  localparam int unsigned NPAL    = 2**CELL_W;
  localparam int unsigned FC_W    = BLINK_LOG2 + 1;

  logic [9:0]  r_h, r_v, w_h_next, w_v_next;
  logic        w_line_end, w_snap;
  logic        r_pf_in_x, r_pf_in_y, r_pv_in_x, r_pv_in_y;
  logic [TX_W-1:0]  r_pf_tx;
  logic [TY_W-1:0]  r_pf_ty;
  logic [1:0]       r_pv_tx;
  logic             r_pv_ty;
  logic [OFF_W-1:0] r_pf_ox, r_pf_oy, r_pv_ox, r_pv_oy;
  logic [GRID_COLS*GRID_ROWS*CELL_W-1:0] r_sh_cells;
  logic [2:0]       r_sh_next;
  logic             r_sh_fail;
  logic [FC_W-1:0]  r_frame;
  logic [CELL_W-1:0] w_cell [NCELLS];
  logic [11:0]       w_pal [NPAL];
  logic [CIDX_W-1:0] w_cell_idx;
  logic [7:0]        w_shape;
  logic              r1_vis, r1_pf, r1_pv;
  logic [CELL_W-1:0] r1_cell, w_pal_idx;
  logic [OFF_W-1:0]  r1_ox, r1_oy;
  logic              w_border, w_blink, w_hs_raw, w_vs_raw, r_hs_d1, r_vs_d1;
  logic [11:0]       w_color;

  for (genvar gi = 0; gi < NCELLS; gi++) begin : g_cell
    assign w_cell[gi] = r_sh_cells[gi*CELL_W +: CELL_W];
  end
  for (genvar gp = 0; gp < NPAL; gp++) begin : g_pal
    assign w_pal[gp] = PALETTE[gp*12 +: 12];
  end

  always_comb begin
    w_line_end = (r_h == 10'(H_TOTAL - 1));
    w_h_next   = w_line_end ? 10'd0 : r_h + 10'd1;
    w_v_next   = r_v;
    if (w_line_end) w_v_next = (r_v == 10'(V_TOTAL - 1)) ? 10'd0 : r_v + 10'd1;
    w_snap     = (r_h == 10'd0) && (r_v == 10'(V_VIS));
    w_hs_raw   = !((r_h >= 10'd656) && (r_h <= 10'd751));
    w_vs_raw   = !((r_v >= 10'd490) && (r_v <= 10'd491));
    w_cell_idx = CIDX_W'(r_pf_ty) * CIDX_W'(GRID_COLS) + CIDX_W'(r_pf_tx);
  end

  // ROM address is issued one pixel ahead so its data lines up with stage 1.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_h     <= '0;
      r_v     <= '0;
      bg_addr <= '0;
    end else begin
      r_h     <= w_h_next;
      r_v     <= w_v_next;
      bg_addr <= 19'(w_v_next) * 19'd640 + 19'(w_h_next);
    end
  end

  // Incremental tile index / pixel offset trackers for playfield and preview.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pf_in_x <= (ORG_X == 0);  r_pf_tx <= '0; r_pf_ox <= '0;
      r_pf_in_y <= (ORG_Y == 0);  r_pf_ty <= '0; r_pf_oy <= '0;
      r_pv_in_x <= (PREV_X == 0); r_pv_tx <= '0; r_pv_ox <= '0;
      r_pv_in_y <= (PREV_Y == 0); r_pv_ty <= '0; r_pv_oy <= '0;
    end else begin
      if (w_h_next == 10'(ORG_X)) begin
        r_pf_in_x <= 1'b1; r_pf_tx <= '0; r_pf_ox <= '0;
      end else if (r_pf_in_x) begin
        if (r_pf_ox == OFF_W'(TILE_PX - 1)) begin
          r_pf_ox <= '0;
          if (r_pf_tx == TX_W'(GRID_COLS - 1)) r_pf_in_x <= 1'b0;
          else r_pf_tx <= r_pf_tx + TX_W'(1);
        end else r_pf_ox <= r_pf_ox + OFF_W'(1);
      end
      if (w_h_next == 10'(PREV_X)) begin
        r_pv_in_x <= 1'b1; r_pv_tx <= '0; r_pv_ox <= '0;
      end else if (r_pv_in_x) begin
        if (r_pv_ox == OFF_W'(TILE_PX - 1)) begin
          r_pv_ox <= '0;
          if (r_pv_tx == 2'd3) r_pv_in_x <= 1'b0;
          else r_pv_tx <= r_pv_tx + 2'd1;
        end else r_pv_ox <= r_pv_ox + OFF_W'(1);
      end
      if (w_line_end) begin
        if (w_v_next == 10'(ORG_Y)) begin
          r_pf_in_y <= 1'b1; r_pf_ty <= '0; r_pf_oy <= '0;
        end else if (r_pf_in_y) begin
          if (r_pf_oy == OFF_W'(TILE_PX - 1)) begin
            r_pf_oy <= '0;
            if (r_pf_ty == TY_W'(GRID_ROWS - 1)) r_pf_in_y <= 1'b0;
            else r_pf_ty <= r_pf_ty + TY_W'(1);
          end else r_pf_oy <= r_pf_oy + OFF_W'(1);
        end
        if (w_v_next == 10'(PREV_Y)) begin
          r_pv_in_y <= 1'b1; r_pv_ty <= 1'b0; r_pv_oy <= '0;
        end else if (r_pv_in_y) begin
          if (r_pv_oy == OFF_W'(TILE_PX - 1)) begin
            r_pv_oy <= '0;
            if (r_pv_ty) r_pv_in_y <= 1'b0;
            else r_pv_ty <= 1'b1;
          end else r_pv_oy <= r_pv_oy + OFF_W'(1);
        end
      end
    end
  end

  // Shadow inputs once per frame, in blanking, so a frame never tears.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sh_cells  <= '0;
      r_sh_next   <= '0;
      r_sh_fail   <= 1'b0;
      r_frame     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (w_h_next == 10'd0) && (w_v_next == 10'(V_VIS));
      if (w_snap) begin
        r_sh_cells <= cell_data;
        r_sh_next  <= next_type;
        r_sh_fail  <= fail;
        r_frame    <= r_frame + FC_W'(1);
      end
    end
  end

  always_comb begin
    case (r_sh_next)
      3'd0:    w_shape = 8'hF0;
      3'd1:    w_shape = 8'h33;
      3'd2:    w_shape = 8'h72;
      3'd3:    w_shape = 8'h74;
      3'd4:    w_shape = 8'h63;
      default: w_shape = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r1_vis  <= 1'b0;
      r1_pf   <= 1'b0;
      r1_pv   <= 1'b0;
      r1_cell <= '0;
      r1_ox   <= '0;
      r1_oy   <= '0;
    end else begin
      r1_vis  <= (r_h < 10'(H_VIS)) && (r_v < 10'(V_VIS));
      r1_pf   <= r_pf_in_x && r_pf_in_y;
      r1_pv   <= r_pv_in_x && r_pv_in_y && w_shape[{r_pv_ty, r_pv_tx}];
      r1_cell <= w_cell[w_cell_idx];
      r1_ox   <= r_pf_ox;
      r1_oy   <= r_pf_oy;
    end
  end

  // Colour priority: blanking, preview, occupied cell, background.
  always_comb begin
    w_pal_idx = CELL_W'(r_sh_next) + CELL_W'(1);
    w_border  = (r1_ox == '0) || (r1_ox == OFF_W'(TILE_PX - 1)) ||
                (r1_oy == '0) || (r1_oy == OFF_W'(TILE_PX - 1));
    w_blink   = r_sh_fail && r_frame[BLINK_LOG2];
    w_color   = bg_data;
    if (!r1_vis) w_color = 12'h000;
    else if (r1_pv) w_color = w_pal[w_pal_idx];
    else if (r1_pf && (r1_cell != '0)) begin
      if (w_blink)       w_color = FAIL_COLOR;
      else if (w_border) w_color = BORDER_COLOR;
      else               w_color = w_pal[r1_cell];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r       <= '0;
      g       <= '0;
      b       <= '0;
      r_hs_d1 <= 1'b1;
      r_vs_d1 <= 1'b1;
      hs      <= 1'b1;
      vs      <= 1'b1;
    end else begin
      {r, g, b} <= w_color;
      r_hs_d1   <= w_hs_raw;
      r_vs_d1   <= w_vs_raw;
      hs        <= r_hs_d1;
      vs        <= r_vs_d1;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: a default instance plus a narrow-grid,
// fast-blink instance, each fed by a registered background ROM model.
`timescale 1ns/1ps
module tb_tile_renderer;

  localparam int unsigned FRAME = 420000;

  logic clk = 1'b0;
  logic clr;
  logic [599:0] cd_a;
  logic [239:0] cd_b;
  logic [2:0]  nt_a, nt_b;
  logic        fail_a, fail_b;
  logic [18:0] addr_a, addr_b;
  logic [11:0] bgd_a, bgd_b;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  int unsigned cyc;
  int          errors = 0;
  int          checks = 0;

  tile_renderer dut_a (
    .clk(clk), .clr(clr), .cell_data(cd_a), .next_type(nt_a), .fail(fail_a),
    .bg_addr(addr_a), .bg_data(bgd_a), .hs(hs_a), .vs(vs_a),
    .r(r_a), .g(g_a), .b(b_a), .frame_start(fs_a)
  );

  tile_renderer #(.GRID_COLS(4), .TILE_PX(8), .BLINK_LOG2(0)) dut_b (
    .clk(clk), .clr(clr), .cell_data(cd_b), .next_type(nt_b), .fail(fail_b),
    .bg_addr(addr_b), .bg_data(bgd_b), .hs(hs_b), .vs(vs_b),
    .r(r_b), .g(g_b), .b(b_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge clr)
    if (clr) cyc <= 0;
    else     cyc <= cyc + 1;

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) begin
    bgd_a <= addr_a[11:0] ^ 12'hA5A;
    bgd_b <= addr_b[11:0] ^ 12'hA5A;
  end

  function automatic logic [31:0] bg_of(input int unsigned x, input int unsigned y);
    return 32'((12'(640 * y + x)) ^ 12'hA5A);
  endfunction

  function automatic int unsigned pk(input int unsigned f, input int unsigned x,
                                     input int unsigned y);
    return f * FRAME + y * 800 + x + 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic goto(input int unsigned k);
    while (cyc < k) @(negedge clk);
  endtask

  function automatic logic [31:0] pa();
    return 32'({r_a, g_a, b_a});
  endfunction

  function automatic logic [31:0] pb();
    return 32'({r_b, g_b, b_b});
  endfunction

  initial begin
    #13_000_000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; cd_a = '0; cd_b = '0; nt_a = 3'd7; nt_b = 3'd7; fail_a = 1'b0; fail_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb",  pa(), 32'h0);
    chk("rst_sync", 32'({hs_a, vs_a}), 32'h3);
    chk("rst_addr", 32'(addr_a), 32'h0);
    chk("rst_fs",   32'(fs_a), 32'h0);
    clr = 1'b0;

    // Reset mid-line must clear outputs immediately.
    repeat (500) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("midrst_addr", 32'(addr_a), 32'h0);
    chk("midrst_rgb",  pa(), 32'h0);
    @(negedge clk);
    clr = 1'b0;

    cd_a[2:0] = 3'd3; cd_a[33 +: 3] = 3'd5; nt_a = 3'd2;
    cd_b[2:0] = 3'd1; cd_b[9 +: 3]  = 3'd2; nt_b = 3'd6; fail_b = 1'b1;

    goto(1);   chk("lat_cyc1", pa(), 32'h0);
    goto(2);   chk("px_0_0",   pa(), bg_of(0, 0));
    goto(657); chk("hs_655", 32'(hs_a), 32'h1);
    goto(658); chk("hs_656", 32'(hs_a), 32'h0);
    goto(753); chk("hs_751", 32'(hs_a), 32'h0);
    goto(754); chk("hs_752", 32'(hs_a), 32'h1);
    goto(pk(0, 209, 106)); chk("f0_noshadow", pa(), bg_of(209, 106));
    goto(383999); chk("fs_before", 32'(fs_a), 32'h0);
    goto(384000); chk("fs_pulse",  32'(fs_a), 32'h1);
    goto(384001); chk("fs_after",  32'(fs_a), 32'h0);
    goto(392001); chk("vs_489", 32'(vs_a), 32'h1);
    goto(392002); chk("vs_490", 32'(vs_a), 32'h0);
    goto(393602); chk("vs_492", 32'(vs_a), 32'h1);

    // Frame 1: first frame rendered from shadows.
    goto(pk(1, 208, 105));
    chk("a_border_00", pa(), 32'h000);
    chk("b_blink_bd",  pb(), 32'hF00);
    goto(pk(1, 209, 106)); chk("a_cell_00",  pa(), 32'hF80);
    goto(pk(1, 221, 106)); chk("a_border_r", pa(), 32'h000);
    goto(pk(1, 222, 106)); chk("a_bg_01",    pa(), bg_of(222, 106));
    goto(pk(1, 210, 107)); chk("b_blink_00", pb(), 32'hF00);
    goto(pk(1, 235, 107)); chk("b_blink_03", pb(), 32'hF00);
    goto(pk(1, 239, 107)); chk("b_blink_end", pb(), 32'hF00);
    goto(pk(1, 240, 107)); chk("b_past_end", pb(), bg_of(240, 107));
    goto(pk(1, 228, 125)); chk("a_cell_11",  pa(), 32'h0F0);
    goto(FRAME + 200 * 800);
    cd_a[33 +: 3] = 3'd0; cd_a[570 +: 3] = 3'd4;
    goto(pk(1, 650, 200)); chk("a_hblank",   pa(), 32'h000);
    goto(pk(1, 382, 279)); chk("a_pv1_edge", pa(), 32'hF80);
    goto(pk(1, 370, 283)); chk("a_pv0_bg",   pa(), bg_of(370, 283));
    goto(pk(1, 385, 283));
    chk("a_pv1", pa(), 32'hF80);
    chk("b_pv_none", pb(), bg_of(385, 283));
    goto(pk(1, 370, 300)); chk("a_pv4",    pa(), 32'hF80);
    goto(pk(1, 415, 300)); chk("a_pv7_bg", pa(), bg_of(415, 300));
    goto(pk(1, 212, 375)); chk("a_notear", pa(), bg_of(212, 375));
    goto(FRAME + 384000);  chk("fs_f1", 32'(fs_a), 32'h1);

    // Frame 2: new data visible, blink phase off for the narrow instance.
    goto(pk(2, 208, 105)); chk("b_border_00", pb(), 32'h000);
    goto(pk(2, 210, 107)); chk("b_cell_00",   pb(), 32'h0FF);
    goto(pk(2, 237, 107)); chk("b_cell_03",   pb(), 32'h00F);
    goto(pk(2, 239, 107)); chk("b_border_03", pb(), 32'h000);
    goto(pk(2, 228, 125)); chk("a_cleared",   pa(), bg_of(228, 125));
    goto(pk(2, 212, 375)); chk("a_new_cell",  pa(), 32'hFF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_renderer.md
TILE_RENDERER -- requirements
Module: tile_renderer

Parameters
REQ-001 SHALL have parameter GRID_COLS, default 10, number of playfield tile columns.
REQ-002 SHALL have parameter GRID_ROWS, default 20, number of playfield tile rows.
REQ-003 SHALL have parameter CELL_W, default 3, bits per cell; value 0 means empty, nonzero is a palette index.
REQ-004 SHALL have parameter TILE_PX, default 14, tile edge length in pixels; legal range 4-32.
REQ-005 SHALL have parameters ORG_X/ORG_Y, default 208/105, playfield top-left pixel; PREV_X/PREV_Y, default 368/279, preview top-left pixel.
REQ-006 SHALL have parameter PALETTE, default implementation-chosen, packed 2^CELL_W x 12-bit rrrr_gggg_bbbb entries; BORDER_COLOR, default 12'h000; FAIL_COLOR, default 12'hF00; BLINK_LOG2, default 4.

Interface
REQ-007 clk  in  1  25 MHz pixel clock.
REQ-008 clr  in  1  reset, asynchronous, active-high.
REQ-009 cell_data  in  GRID_COLS*GRID_ROWS*CELL_W  playfield; cell (r,c) at bits [(r*GRID_COLS+c)*CELL_W +: CELL_W].
REQ-010 next_type  in  3  preview piece type, 0-4 valid, 5-7 none.
REQ-011 fail  in  1  game-over flag.
REQ-012 bg_addr  out  19  background ROM address, 640*y+x.
REQ-013 bg_data  in  12  background ROM data, valid exactly 1 cycle after bg_addr.
REQ-014 hs, vs  out  1 each  active-low syncs; r, g, b  out  4 each  colour.
REQ-015 frame_start  out  1  one-cycle pulse at the snapshot cycle (REQ-021).

Function
REQ-016 Timing: h counter 0-799 (visible 0-639, sync 656-751); v counter 0-524 (visible 0-479, sync 490-491); v increments when h wraps 799->0.
REQ-017 Tile location SHALL be tracked by incremental tile-index/pixel-offset counters reset at ORG_X/ORG_Y (resp. PREV_X/PREV_Y) and wrapping at TILE_PX; no dividers.
REQ-018 Pipeline: stage 0 counters; stage 1 registers bg_addr, region flags, cell value, tile offset; stage 2 registers r,g,b. hs/vs SHALL be delayed 2 cycles so they align with colour.
REQ-019 Pixel colour priority: outside visible area -> 0; preview region with shape tile -> PALETTE[next_type+1]; playfield cell nonzero -> PALETTE[cell], with BORDER_COLOR at tile offset 0 or TILE_PX-1 on either axis; otherwise bg_data.
REQ-020 Preview is 2 rows x 4 cols; index = row*4+col; shapes: 0 -> {4,5,6,7}; 1 -> {0,1,4,5}; 2 -> {1,4,5,6}; 3 -> {2,4,5,6}; 4 -> {0,1,5,6}; 5-7 -> none.
REQ-021 Snapshot: at h=0, v=480, cell_data, next_type and fail SHALL be captured into shadow registers; rendering uses shadows only; frame_start pulses that cycle.
REQ-022 Frame counter (BLINK_LOG2+1 bits) increments at each snapshot, wrapping freely.
REQ-023 When shadow fail=1 and frame counter bit BLINK_LOG2 = 1, nonzero playfield cells SHALL render FAIL_COLOR (borders included); preview unaffected.
REQ-024 Input changes mid-frame SHALL NOT affect the current frame (no tearing).
REQ-025 Pixels where the playfield and preview regions overlap SHALL follow preview priority.

Reset
REQ-026 On clr: h=v=0, shadows=0, frame counter=0, r=g=b=0, hs=vs=1, bg_addr=0, frame_start=0, pipeline flags cleared.
REQ-027 clr asserted mid-frame SHALL take effect immediately; after release, the first active pixel SHALL appear 2 cycles after h=0, v=0.
REQ-028 Before the first snapshot, shadows are 0: the display shows background only.

Verification
REQ-029 Reset then free-run: hs low for 96 clocks per 800-clock line; vs low for 2 lines per 525; frame_start once per 420000 cycles.
REQ-030 cell_data with cell (0,0)=3, rest 0, after snapshot: pixel (208,105) = BORDER_COLOR; (209,106) = PALETTE[3]; (222,106) = bg_data.
REQ-031 next_type=2: preview tile index 1 (pixels 382-395, 279-292) = PALETTE[3]; tile index 0 = background; next_type=6 -> whole preview is background.
REQ-032 Change cell_data at v=200: rows 200-479 unchanged; new data visible in the next frame.
REQ-033 fail=1 with occupied cells: colour alternates PALETTE/FAIL_COLOR every 16 frames (BLINK_LOG2=4).
REQ-034 Override to GRID_COLS=4, TILE_PX=8: playfield ends at pixel ORG_X+31, and the pixel at ORG_X+32 is background.
